// File: rtl/regroup_table_arbiter_pkg.sv
// Shared definitions for the regroup lookup RAM arbiter.
//   REGROUP_RAM_AW/DW/DEPTH : geometry of the regroup lookup RAM
//   regroup_state_e         : arbiter FSM states (table clear, normal run)
package regroup_table_arbiter_pkg;

  localparam int unsigned REGROUP_RAM_AW    = 8;
  localparam int unsigned REGROUP_RAM_DW    = 71;
  localparam int unsigned REGROUP_RAM_DEPTH = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } regroup_state_e;

endpackage

// File: rtl/regroup_table_arbiter.sv
// Arbiter for the single-port regroup lookup RAM shared by the last-node
// lookup engine and the host configuration path.
//   After reset the whole table is written with zero (INIT), then one access
//   per cycle is granted (RUN). Lookup wins ties unless a pending config
//   request has already lost MAX_STARVE times in a row. Read data is steered
//   back to whichever requester issued the read.
// Ports:
//   i_clk, i_rst                   clock, async active-high reset
//   i_lkp_rd/iv_lkp_raddr          lookup read request (held until o_lkp_ack)
//   o_lkp_ack                      lookup accepted this cycle
//   ov_lkp_rdata/o_lkp_rdata_valid lookup read return
//   i_cfg_wr/i_cfg_rd/iv_cfg_addr/iv_cfg_wdata  config request (held until ack)
//   o_cfg_ack                      config accepted this cycle
//   ov_cfg_rdata/o_cfg_rdata_valid config read return
//   o_ram_rd/o_ram_wr/ov_ram_addr/ov_ram_wdata/iv_ram_rdata  RAM port
//   o_init_done                    table clear complete
module regroup_table_arbiter
  import regroup_table_arbiter_pkg::*;
#(
  parameter int unsigned RAM_RD_LAT = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lkp_rd,
  input  logic [7:0]  iv_lkp_raddr,
  output logic        o_lkp_ack,
  output logic [70:0] ov_lkp_rdata,
  output logic        o_lkp_rdata_valid,
  input  logic        i_cfg_wr,
  input  logic        i_cfg_rd,
  input  logic [7:0]  iv_cfg_addr,
  input  logic [70:0] iv_cfg_wdata,
  output logic        o_cfg_ack,
  output logic [70:0] ov_cfg_rdata,
  output logic        o_cfg_rdata_valid,
  output logic        o_ram_rd,
  output logic        o_ram_wr,
  output logic [7:0]  ov_ram_addr,
  output logic [70:0] ov_ram_wdata,
  input  logic [70:0] iv_ram_rdata,
  output logic        o_init_done
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
  localparam logic [REGROUP_RAM_AW-1:0] LAST_ADDR = REGROUP_RAM_AW'(REGROUP_RAM_DEPTH - 1);

  regroup_state_e state_q, state_d;
  logic [REGROUP_RAM_AW-1:0] init_addr_q, init_addr_d;
  logic [3:0]                starve_q, starve_d;
  logic                      ram_rd_q, ram_rd_d;
  logic                      ram_wr_q, ram_wr_d;
  logic [REGROUP_RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [REGROUP_RAM_DW-1:0] ram_wdata_q, ram_wdata_d;
  logic                      init_done_q;

  // Return tag pipeline: stage k is aligned with the k-th cycle after the
  // read strobe, so stage RAM_RD_LAT sees the cycle in which iv_ram_rdata
  // is valid for that read.
  logic [RAM_RD_LAT:0]       vld_q;
  logic [RAM_RD_LAT:0]       tag_lkp_q;
  logic                      tag_lkp_d;

  logic [REGROUP_RAM_DW-1:0] lkp_rdata_q, cfg_rdata_q;
  logic                      lkp_vld_q, cfg_vld_q;

  logic cfg_req;
  logic lkp_ack;
  logic cfg_ack;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    starve_d    = starve_q;
    lkp_ack     = 1'b0;
    cfg_ack     = 1'b0;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_lkp_d   = 1'b0;
    cfg_req     = i_cfg_wr | i_cfg_rd;

    case (state_q)
      ST_INIT: begin
        ram_wr_d    = 1'b1;
        ram_addr_d  = init_addr_q;
        ram_wdata_d = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_lkp_rd && !(cfg_req && (starve_q == STARVE_MAX))) begin
          lkp_ack = 1'b1;
        end else if (cfg_req) begin
          cfg_ack = 1'b1;
        end

        if (lkp_ack) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = iv_lkp_raddr;
          tag_lkp_d  = 1'b1;
        end else if (cfg_ack) begin
          ram_addr_d = iv_cfg_addr;
          // A simultaneous write+read serves only the write; the read is
          // left for the requester to present again.
          if (i_cfg_wr) begin
            ram_wr_d    = 1'b1;
            ram_wdata_d = iv_cfg_wdata;
          end else begin
            ram_rd_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (!cfg_req || cfg_ack) begin
      starve_d = '0;
    end else if (lkp_ack && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      starve_q    <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
      tag_lkp_q   <= '0;
      lkp_rdata_q <= '0;
      cfg_rdata_q <= '0;
      lkp_vld_q   <= 1'b0;
      cfg_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      starve_q    <= starve_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      init_done_q <= (state_q == ST_RUN);

      if (RAM_RD_LAT > 0) begin
        vld_q     <= {vld_q[RAM_RD_LAT-1:0], ram_rd_d};
        tag_lkp_q <= {tag_lkp_q[RAM_RD_LAT-1:0], tag_lkp_d};
      end else begin
        vld_q     <= ram_rd_d;
        tag_lkp_q <= tag_lkp_d;
      end

      lkp_vld_q <= vld_q[RAM_RD_LAT] & tag_lkp_q[RAM_RD_LAT];
      cfg_vld_q <= vld_q[RAM_RD_LAT] & ~tag_lkp_q[RAM_RD_LAT];
      if (vld_q[RAM_RD_LAT] && tag_lkp_q[RAM_RD_LAT]) begin
        lkp_rdata_q <= iv_ram_rdata;
      end
      if (vld_q[RAM_RD_LAT] && !tag_lkp_q[RAM_RD_LAT]) begin
        cfg_rdata_q <= iv_ram_rdata;
      end
    end
  end

  assign o_lkp_ack         = lkp_ack;
  assign o_cfg_ack         = cfg_ack;
  assign o_ram_rd          = ram_rd_q;
  assign o_ram_wr          = ram_wr_q;
  assign ov_ram_addr       = ram_addr_q;
  assign ov_ram_wdata      = ram_wdata_q;
  assign ov_lkp_rdata      = lkp_rdata_q;
  assign o_lkp_rdata_valid = lkp_vld_q;
  assign ov_cfg_rdata      = cfg_rdata_q;
  assign o_cfg_rdata_valid = cfg_vld_q;
  assign o_init_done       = init_done_q;

endmodule

// File: tb/tb_regroup_table_arbiter.sv
// Self-checking bench for regroup_table_arbiter with a behavioural RAM.
module tb_regroup_table_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned STV = 4;

  localparam logic [1:0] OP_CW = 2'd0;
  localparam logic [1:0] OP_CR = 2'd1;
  localparam logic [1:0] OP_LR = 2'd2;

  localparam logic [70:0] D_ONES = {71{1'b1}};
  localparam logic [70:0] D_FF   = 71'h40_0000_0000_0000_0001;
  localparam logic [70:0] D_12A  = 71'h1_2345;
  localparam logic [70:0] D_12B  = 71'h2A_AAAA_AAAA_AAAA_AAAA;
  localparam logic [70:0] D_33   = 71'h15_5555_0000_1234_ABCD;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_rd;
  logic [7:0]  lkp_raddr;
  logic        lkp_ack;
  logic [70:0] lkp_rdata;
  logic        lkp_vld;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [7:0]  cfg_addr;
  logic [70:0] cfg_wdata;
  logic        cfg_ack;
  logic [70:0] cfg_rdata;
  logic        cfg_vld;
  logic        ram_rd;
  logic        ram_wr;
  logic [7:0]  ram_addr;
  logic [70:0] ram_wdata;
  logic [70:0] ram_rdata;
  logic        init_done;

  regroup_table_arbiter #(.RAM_RD_LAT(LAT), .MAX_STARVE(STV)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lkp_rd(lkp_rd), .iv_lkp_raddr(lkp_raddr), .o_lkp_ack(lkp_ack),
    .ov_lkp_rdata(lkp_rdata), .o_lkp_rdata_valid(lkp_vld),
    .i_cfg_wr(cfg_wr), .i_cfg_rd(cfg_rd), .iv_cfg_addr(cfg_addr),
    .iv_cfg_wdata(cfg_wdata), .o_cfg_ack(cfg_ack),
    .ov_cfg_rdata(cfg_rdata), .o_cfg_rdata_valid(cfg_vld),
    .o_ram_rd(ram_rd), .o_ram_wr(ram_wr), .ov_ram_addr(ram_addr),
    .ov_ram_wdata(ram_wdata), .iv_ram_rdata(ram_rdata),
    .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with LAT cycles of read latency.
  logic [70:0] mem [256];
  logic [70:0] rpipe [LAT];
  always @(posedge clk) begin
    if (ram_rd) rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    if (ram_wr) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = rpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          lkp_vcnt = 0;
  int          cfg_vcnt = 0;
  logic [70:0] lkp_last = '0;
  logic [70:0] cfg_last = '0;
  always @(negedge clk) begin
    if (lkp_vld) begin lkp_vcnt <= lkp_vcnt + 1; lkp_last <= lkp_rdata; end
    if (cfg_vld) begin cfg_vcnt <= cfg_vcnt + 1; cfg_last <= cfg_rdata; end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // All stimulus and sampling happens 1 time unit after a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lkp_rd = 1'b0; cfg_wr = 1'b0; cfg_rd = 1'b0;
  endtask

  task automatic wait_valid(input bit is_lkp, input int t_ack, input logic [70:0] exp,
                            input string name);
    int  l0, c0;
    bit  seen;
    l0 = lkp_vcnt; c0 = cfg_vcnt;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (is_lkp ? lkp_vld : cfg_vld) seen = 1'b1;
      else step();
    end
    chk({name, "_valid_seen"}, 71'(seen), 71'd1);
    if (seen) begin
      chk({name, "_latency"}, 71'(cyc - t_ack), 71'(LAT + 2));
      chk({name, "_data"}, is_lkp ? lkp_rdata : cfg_rdata, exp);
      chk({name, "_other_bus_quiet"}, 71'(is_lkp ? (cfg_vcnt - c0) : (lkp_vcnt - l0)), 71'd0);
      step();
      chk({name, "_single_pulse"}, 71'(is_lkp ? lkp_vld : cfg_vld), 71'd0);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] addr, input logic [70:0] wd,
                       input logic [70:0] exp, input string name);
    bit got;
    int t_ack;
    idle_inputs();
    if (op == OP_LR) begin lkp_rd = 1'b1; lkp_raddr = addr; end
    else begin
      cfg_addr = addr; cfg_wdata = wd;
      if (op == OP_CW) cfg_wr = 1'b1; else cfg_rd = 1'b1;
    end
    #1;
    got = 1'b0;
    t_ack = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((op == OP_LR) ? lkp_ack : cfg_ack) begin got = 1'b1; t_ack = cyc; end
      else step();
    end
    chk({name, "_ack"}, 71'(got), 71'd1);
    if (!got) begin idle_inputs(); return; end
    step();
    idle_inputs();
    chk({name, "_ram_addr"}, 71'(ram_addr), 71'(addr));
    if (op == OP_CW) begin
      chk({name, "_ram_strobes"}, 71'({ram_wr, ram_rd}), 71'b10);
      chk({name, "_ram_wdata"}, ram_wdata, wd);
    end else begin
      chk({name, "_ram_strobes"}, 71'({ram_wr, ram_rd}), 71'b01);
      wait_valid(op == OP_LR, t_ack, exp, name);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [70:0] wdata;
    logic [70:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int init_bad;
    int l0, c0, t_ack;
    bit got;

    vecs[0] = '{OP_CW, 8'h12, D_12A,  '0,     "cw12"};
    vecs[1] = '{OP_LR, 8'h12, '0,     D_12A,  "lr12"};
    vecs[2] = '{OP_CW, 8'h00, D_ONES, '0,     "cw00"};
    vecs[3] = '{OP_CW, 8'hFF, D_FF,   '0,     "cwff"};
    vecs[4] = '{OP_CR, 8'hFF, '0,     D_FF,   "crff"};
    vecs[5] = '{OP_LR, 8'h00, '0,     D_ONES, "lr00"};
    vecs[6] = '{OP_CR, 8'h55, '0,     '0,     "cr55_cleared"};
    vecs[7] = '{OP_LR, 8'hFF, '0,     D_FF,   "lrff"};
    vecs[8] = '{OP_CW, 8'h12, D_12B,  '0,     "cw12b"};
    vecs[9] = '{OP_CR, 8'h12, '0,     D_12B,  "cr12b"};

    rst = 1'b1;
    idle_inputs();
    lkp_raddr = '0; cfg_addr = '0; cfg_wdata = '0;
    step(); step();

    // Reset state.
    chk("rst_strobes", 71'({ram_rd, ram_wr}), 71'd0);
    chk("rst_ram_addr", 71'(ram_addr), 71'd0);
    chk("rst_ram_wdata", ram_wdata, '0);
    chk("rst_rdata_buses", lkp_rdata | cfg_rdata, '0);
    chk("rst_valids_done", 71'({lkp_vld, cfg_vld, init_done}), 71'd0);

    // Table clear: lookup held high must not be acked during INIT.
    lkp_rd = 1'b1;
    rst = 1'b0;
    init_bad = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (!ram_wr || ram_rd || ram_addr != 8'(k) || ram_wdata != '0 || init_done) init_bad++;
      if (k < 255 && (lkp_ack || cfg_ack)) init_bad++;
      if (k == 254) lkp_rd = 1'b0;
    end
    chk("init_sequence_errs", 71'(init_bad), 71'd0);
    step();
    chk("init_done_rise", 71'(init_done), 71'd1);
    chk("init_no_more_writes", 71'({ram_wr, ram_rd}), 71'd0);

    // Directed single transactions.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
    end

    // Starvation bound: lookup and config read both held for 10 cycles.
    step();
    l0 = lkp_vcnt; c0 = cfg_vcnt;
    lkp_rd = 1'b1; lkp_raddr = 8'h00;
    cfg_rd = 1'b1; cfg_addr = 8'hFF;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_grant_%0d", i), 71'({lkp_ack, cfg_ack}),
          (i % 5 == 4) ? 71'b01 : 71'b10);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
    chk("starve_lkp_returns", 71'(lkp_vcnt - l0), 71'd8);
    chk("starve_cfg_returns", 71'(cfg_vcnt - c0), 71'd2);
    chk("starve_lkp_data", lkp_last, D_ONES);
    chk("starve_cfg_data", cfg_last, D_FF);

    // Config write and read requested together.
    cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = 8'h33; cfg_wdata = D_33;
    #1;
    chk("wrrd_first_ack", 71'(cfg_ack), 71'd1);
    step();
    cfg_wr = 1'b0;
    chk("wrrd_ram_strobes", 71'({ram_wr, ram_rd}), 71'b10);
    chk("wrrd_ram_wdata", ram_wdata, D_33);
    #1;
    got = cfg_ack;
    t_ack = cyc;
    chk("wrrd_read_ack", 71'(got), 71'd1);
    step();
    idle_inputs();
    chk("wrrd_read_strobe", 71'({ram_wr, ram_rd}), 71'b01);
    if (got) wait_valid(1'b0, t_ack, D_33, "wrrd_read");

    // Reset one cycle after a lookup ack discards the read.
    step();
    lkp_rd = 1'b1; lkp_raddr = 8'h12;
    #1;
    chk("rstmid_ack", 71'(lkp_ack), 71'd1);
    step();
    idle_inputs();
    l0 = lkp_vcnt; c0 = cfg_vcnt;
    rst = 1'b1;
    #1;
    chk("rstmid_strobes_cleared", 71'({ram_rd, ram_wr, init_done}), 71'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rstmid_init_restart", 71'({ram_wr, ram_addr}), 71'({1'b1, 8'h00}));
    for (int i = 0; i < 8; i++) step();
    chk("rstmid_no_valid", 71'((lkp_vcnt - l0) + (cfg_vcnt - c0)), 71'd0);
    chk("rstmid_init_addr", 71'(ram_addr), 71'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
